// File: rtl/i2s_sample_feeder_pkg.sv
// i2s_sample_feeder_pkg: sample width and FIFO depth defaults shared with the I2S sender
package i2s_sample_feeder_pkg;
  localparam int SAMPLE_WIDTH = 24;
  localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/i2s_sample_feeder_fifo.sv
// sample_fifo_sync: single-clock sample FIFO with level, full and empty flags
module sample_fifo_sync
  import i2s_sample_feeder_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  // storage write; contents need no reset since level gates every read
  always_ff @(posedge CLK)
    if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: buffers producer samples and prefetches one ahead for an I2S sender
module i2s_sample_feeder
  import i2s_sample_feeder_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       S_DATA,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic                   READ_EN,
  output logic [WIDTH-1:0]       DATA_SOURCE,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   UNDERFLOW,
  input  logic                   CLR_UNDERFLOW
);
  logic sync1, sync2, sync_d, hold_valid;
  logic full, empty, req, pending, preload, pop, push;
  logic [WIDTH-1:0] head;
  assign S_READY = RST & ~full;
  assign push = S_VALID & S_READY;
  assign req = sync2 & ~sync_d;
  assign pending = req | (sync1 & ~sync2);
  assign preload = ~hold_valid & ~pending & ~empty;
  assign pop = (req & ~empty) | preload;
  sample_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .wr_en(push),
    .wr_data(S_DATA),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(LEVEL)
  );
  // two-flop synchronizer plus edge flop for the READ_EN rise
  always_ff @(posedge CLK or negedge RST)
    if (!RST) {sync_d, sync2, sync1} <= '0;
    else {sync_d, sync2, sync1} <= {sync2, sync1, READ_EN};
  // output register: serve the slot on req, otherwise refill an empty holder
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      DATA_SOURCE <= '0;
      hold_valid <= 1'b0;
    end else if (req) begin
      DATA_SOURCE <= empty ? '0 : head;
      hold_valid <= ~empty;
    end else if (preload) begin
      DATA_SOURCE <= head;
      hold_valid <= 1'b1;
    end
  // sticky underflow; a coincident underflow beats the clear
  always_ff @(posedge CLK or negedge RST)
    if (!RST) UNDERFLOW <= 1'b0;
    else if (req & empty) UNDERFLOW <= 1'b1;
    else if (CLR_UNDERFLOW) UNDERFLOW <= 1'b0;
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb_i2s_sample_feeder: model-compared and directed checks of the sample feeder
module tb_i2s_sample_feeder;
  localparam int W = 24;
  localparam int D = 16;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [W-1:0] S_DATA = '0;
  logic S_VALID = 1'b0;
  logic S_READY;
  logic READ_EN = 1'b0;
  logic [W-1:0] DATA_SOURCE;
  logic [$clog2(D):0] LEVEL;
  logic UNDERFLOW;
  logic CLR_UNDERFLOW = 1'b0;
  int total = 0;
  int bad = 0;

  i2s_sample_feeder dut (
    .CLK(CLK),
    .RST(RST),
    .S_DATA(S_DATA),
    .S_VALID(S_VALID),
    .S_READY(S_READY),
    .READ_EN(READ_EN),
    .DATA_SOURCE(DATA_SOURCE),
    .LEVEL(LEVEL),
    .UNDERFLOW(UNDERFLOW),
    .CLR_UNDERFLOW(CLR_UNDERFLOW)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a queue of samples, the presented sample and the sticky flag;
  // h1..h3 are READ_EN as seen at the last three edges
  logic [W-1:0] q[$];
  logic [W-1:0] m_data = '0;
  logic m_hold = 1'b0;
  logic m_uf = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      q.delete();
      m_data = '0;
      m_hold = 1'b0;
      m_uf = 1'b0;
      {h1, h2, h3} = '0;
    end else begin : step
      logic fire, rise_seen, emp, can_push;
      fire = h2 && !h3;
      rise_seen = fire || (h1 && !h2);
      emp = q.size() == 0;
      can_push = S_VALID && q.size() < D;
      if (fire) begin
        if (emp) begin
          m_data = '0;
          m_hold = 1'b0;
          m_uf = 1'b1;
        end else begin
          m_data = q.pop_front();
          m_hold = 1'b1;
        end
      end else if (!m_hold && !rise_seen && !emp) begin
        m_data = q.pop_front();
        m_hold = 1'b1;
      end
      if (!(fire && emp) && CLR_UNDERFLOW) m_uf = 1'b0;
      if (can_push) q.push_back(S_DATA);
      h3 = h2;
      h2 = h1;
      h1 = READ_EN;
    end
  end

  initial forever begin
    @(negedge CLK);
    check("cmp_data", 32'(DATA_SOURCE), 32'(m_data));
    check("cmp_level", 32'(LEVEL), 32'(q.size()));
    check("cmp_underflow", 32'(UNDERFLOW), 32'(m_uf));
    check("cmp_ready", 32'(S_READY), 32'(RST && q.size() < D));
  end

  task automatic push(input logic [W-1:0] v);
    S_DATA = v;
    S_VALID = 1'b1;
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  task automatic pulse(input int n);
    READ_EN = 1'b1;
    repeat (n) @(negedge CLK);
    READ_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr_uf();
    CLR_UNDERFLOW = 1'b1;
    @(negedge CLK);
    CLR_UNDERFLOW = 1'b0;
  endtask

  logic [W-1:0] t1_exp[4] = '{24'h000002, 24'h000003, 24'h000004, 24'h000000};

  initial begin
    #1 RST = 1'b0;
    #1;
    check("rst_data", 32'(DATA_SOURCE), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_uf", 32'(UNDERFLOW), 0);
    check("rst_ready", 32'(S_READY), 0);
    idle(3);
    RST = 1'b1;

    for (int i = 1; i <= 4; i++) push(W'(i));
    idle(3);
    check("t1_pre_data", 32'(DATA_SOURCE), 32'h1);
    check("t1_pre_level", 32'(LEVEL), 3);
    for (int k = 0; k < 4; k++) begin
      pulse(4);
      idle(124);
      check("t1_slot_data", 32'(DATA_SOURCE), 32'(t1_exp[k]));
    end
    check("t1_uf", 32'(UNDERFLOW), 1);
    clr_uf();
    check("t1_uf_clr", 32'(UNDERFLOW), 0);

    pulse(4);
    idle(10);
    check("t3_data", 32'(DATA_SOURCE), 0);
    check("t3_uf", 32'(UNDERFLOW), 1);
    push(24'hABCDEF);
    @(negedge CLK);
    check("t3_refill", 32'(DATA_SOURCE), 32'hABCDEF);

    clr_uf();
    check("t4_uf_clr", 32'(UNDERFLOW), 0);
    READ_EN = 1'b1;
    idle(2);
    CLR_UNDERFLOW = 1'b1;
    @(negedge CLK);
    CLR_UNDERFLOW = 1'b0;
    check("t4_set_wins", 32'(UNDERFLOW), 1);
    check("t4_data", 32'(DATA_SOURCE), 0);
    @(negedge CLK);
    READ_EN = 1'b0;
    idle(10);
    check("t4_sticky", 32'(UNDERFLOW), 1);
    clr_uf();
    check("t4_later_clr", 32'(UNDERFLOW), 0);

    for (int i = 0; i < 16; i++) push(W'(32'h100 + i));
    check("t2_level15", 32'(LEVEL), 15);
    check("t2_ready15", 32'(S_READY), 1);
    push(24'h000110);
    check("t2_level16", 32'(LEVEL), 16);
    check("t2_ready16", 32'(S_READY), 0);
    push(24'h000111);
    check("t2_reject", 32'(LEVEL), 16);
    check("t2_head", 32'(DATA_SOURCE), 32'h100);

    READ_EN = 1'b1;
    @(negedge CLK);
    check("t5_edge1", 32'(DATA_SOURCE), 32'h100);
    @(negedge CLK);
    check("t5_edge2", 32'(DATA_SOURCE), 32'h100);
    idle(38);
    READ_EN = 1'b0;
    check("t5_level", 32'(LEVEL), 15);
    check("t5_data", 32'(DATA_SOURCE), 32'h101);
    idle(10);
    check("t5_one_pop", 32'(LEVEL), 15);

    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(32'h200 + i));
    check("t6_level7", 32'(LEVEL), 7);
    #3 RST = 1'b0;
    #1;
    check("t6_data", 32'(DATA_SOURCE), 0);
    check("t6_level", 32'(LEVEL), 0);
    check("t6_uf", 32'(UNDERFLOW), 0);
    check("t6_ready", 32'(S_READY), 0);
    idle(2);
    RST = 1'b1;
    push(24'h5A5A5A);
    @(negedge CLK);
    check("t6_first", 32'(DATA_SOURCE), 32'h5A5A5A);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
